counter_arbiter: RTL and testbench

Shared up/down step-counter controller. Two requesters each ask for a run of N count steps in a chosen direction. The block arbitrates round-robin, sequences the granted run one step per clock on an internal WIDTH-bit wrap-around counter, and closes each transaction with a 4-phase req/done handshake. It sits between requester logic and the count value used downstream, as the sequencer for the lab's up/down counter datapath.

---
 rtl/counter_arbiter.sv | 107 ++++++++++
 tb/tb_counter_arbiter.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// Round-robin arbiter that runs one requester's up/down step sequence on a shared
// wrap-around counter and closes each transaction with a 4-phase req/done handshake.
module counter_arbiter #(
   parameter int WIDTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       req,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] steps0,
   input  logic [WIDTH-1:0] steps1,
   output logic [1:0]       gnt,
   output logic [1:0]       done,
   output logic             busy,
   output logic [WIDTH-1:0] count
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] count_nx;
   logic [WIDTH-1:0] remaining, remaining_nx;
   logic [1:0]       gnt_nx, done_nx;
   logic             busy_nx;
   logic             last, last_nx;
   logic             dir, dir_nx;
   logic             winner;
   logic [WIDTH-1:0] win_steps;

   // On contention the requester that was not served last wins.
   always_comb begin
      if (req == 2'b11) winner = ~last;
      else              winner = req[1];
      win_steps = winner ? steps1 : steps0;
   end

   // NOTE: every next-state value defaults to the current value first, so no latch is inferred.
   always_comb begin
      state_nx     = state;
      count_nx     = count;
      remaining_nx = remaining;
      gnt_nx       = gnt;
      done_nx      = done;
      busy_nx      = busy;
      last_nx      = last;
      dir_nx       = dir;
      case (state)
         IDLE: begin
            if (req != 2'b00) begin
               dir_nx       = mode[winner];
               remaining_nx = win_steps;
               gnt_nx       = winner ? 2'b10 : 2'b01;
               last_nx      = winner;
               busy_nx      = 1'b1;
               if (win_steps != '0) begin
                  state_nx = RUN;
               end else begin
                  state_nx = DONE;
                  done_nx  = winner ? 2'b10 : 2'b01;
               end
            end
         end
         RUN: begin
            count_nx     = dir ? count + 1'b1 : count - 1'b1;
            remaining_nx = remaining - 1'b1;
            if (remaining == WIDTH'(1)) begin
               state_nx = DONE;
               done_nx  = gnt;
            end
         end
         DONE: begin
            // The owner of the current transaction is always the last-granted requester.
            if (!req[last]) begin
               state_nx = IDLE;
               gnt_nx   = 2'b00;
               done_nx  = 2'b00;
               busy_nx  = 1'b0;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         count     <= '0;
         remaining <= '0;
         gnt       <= 2'b00;
         done      <= 2'b00;
         busy      <= 1'b0;
         last      <= 1'b1;
         dir       <= 1'b0;
      end else begin
         state     <= state_nx;
         count     <= count_nx;
         remaining <= remaining_nx;
         gnt       <= gnt_nx;
         done      <= done_nx;
         busy      <= busy_nx;
         last      <= last_nx;
         dir       <= dir_nx;
      end
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed testbench for counter_arbiter: hand-computed expectations checked
// with immediate assertions after each clock edge.
module tb_counter_arbiter;

   localparam int WIDTH = 3;

   logic             clk;
   logic             reset;
   logic [1:0]       req;
   logic [1:0]       mode;
   logic [WIDTH-1:0] steps0;
   logic [WIDTH-1:0] steps1;
   logic [1:0]       gnt;
   logic [1:0]       done;
   logic             busy;
   logic [WIDTH-1:0] count;

   int tests_run;
   int tests_failed;

   counter_arbiter #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .reset  (reset),
      .req    (req),
      .mode   (mode),
      .steps0 (steps0),
      .steps1 (steps1),
      .gnt    (gnt),
      .done   (done),
      .busy   (busy),
      .count  (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      tests_run++;
      assert (observed === expected)
      else begin
         tests_failed++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic chk_all(input string tag, input logic [1:0] e_gnt, input logic [1:0] e_done,
                          input logic e_busy, input logic [WIDTH-1:0] e_count);
      chk({tag, ".gnt"},   8'(gnt),   8'(e_gnt));
      chk({tag, ".done"},  8'(done),  8'(e_done));
      chk({tag, ".busy"},  8'(busy),  8'(e_busy));
      chk({tag, ".count"}, 8'(count), 8'(e_count));
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      // Reset held with random inputs
      reset  = 1'b0;
      req    = 2'($urandom);
      mode   = 2'($urandom);
      steps0 = WIDTH'($urandom);
      steps1 = WIDTH'($urandom);
      repeat (3) tick();
      chk_all("reset_held", 2'b00, 2'b00, 1'b0, 3'd0);
      req = 2'b00;
      reset = 1'b1;
      repeat (2) tick();
      chk_all("reset_idle", 2'b00, 2'b00, 1'b0, 3'd0);

      // Up run of 5 steps on requester 0
      req = 2'b01; mode = 2'b01; steps0 = 3'd5;
      tick();
      chk_all("up_grant", 2'b01, 2'b00, 1'b1, 3'd0);
      for (int s = 1; s <= 5; s++) begin
         tick();
         chk("up_count", 8'(count), 8'(s));
         chk("up_done", 8'(done), (s == 5) ? 8'h01 : 8'h00);
      end
      repeat (2) tick();
      chk_all("up_hold", 2'b01, 2'b01, 1'b1, 3'd5);
      req = 2'b00;
      tick();
      chk_all("up_release", 2'b00, 2'b00, 1'b0, 3'd5);

      // Requester 1 down 4: 5 -> 1
      req = 2'b10; mode = 2'b00; steps1 = 3'd4;
      tick();
      chk_all("dn_grant", 2'b10, 2'b00, 1'b1, 3'd5);
      repeat (4) tick();
      chk_all("dn_end", 2'b10, 2'b10, 1'b1, 3'd1);
      req = 2'b00;
      tick();
      chk_all("dn_release", 2'b00, 2'b00, 1'b0, 3'd1);

      // Wrap down from 1: 0, 7, 6
      req = 2'b10; mode = 2'b00; steps1 = 3'd3;
      tick();
      chk_all("wrap_grant", 2'b10, 2'b00, 1'b1, 3'd1);
      tick(); chk("wrap_c0", 8'(count), 8'd0);
      tick(); chk("wrap_c7", 8'(count), 8'd7);
      tick(); chk_all("wrap_c6", 2'b10, 2'b10, 1'b1, 3'd6);
      req = 2'b00;
      tick();
      chk_all("wrap_release", 2'b00, 2'b00, 1'b0, 3'd6);

      // Contention from reset: requester 0 first
      #2 reset = 1'b0;
      #1 reset = 1'b1;
      req = 2'b11; mode = 2'b01; steps0 = 3'd2; steps1 = 3'd1;
      tick();
      chk_all("cont_g0", 2'b01, 2'b00, 1'b1, 3'd0);
      tick(); chk("cont_c1", 8'(count), 8'd1);
      tick(); chk_all("cont_d0", 2'b01, 2'b01, 1'b1, 3'd2);
      req = 2'b10;
      tick();
      chk_all("cont_gap", 2'b00, 2'b00, 1'b0, 3'd2);
      tick();
      chk_all("cont_g1", 2'b10, 2'b00, 1'b1, 3'd2);
      tick();
      chk_all("cont_d1", 2'b10, 2'b10, 1'b1, 3'd1);
      req = 2'b00;
      tick();
      chk_all("cont_idle", 2'b00, 2'b00, 1'b0, 3'd1);
      req = 2'b11;
      tick();
      chk_all("cont_regrant0", 2'b01, 2'b00, 1'b1, 3'd1);
      repeat (2) tick();
      chk_all("cont_rd0", 2'b01, 2'b01, 1'b1, 3'd3);
      req = 2'b00;
      tick();
      chk_all("cont_end", 2'b00, 2'b00, 1'b0, 3'd3);

      // Zero-step request
      req = 2'b01; mode = 2'b00; steps0 = 3'd0;
      tick();
      chk_all("zero_grant", 2'b01, 2'b01, 1'b1, 3'd3);
      tick();
      chk_all("zero_hold", 2'b01, 2'b01, 1'b1, 3'd3);
      req = 2'b00;
      tick();
      chk_all("zero_release", 2'b00, 2'b00, 1'b0, 3'd3);

      // Drop req mid-run: run completes, done pulses once
      req = 2'b01; mode = 2'b01; steps0 = 3'd3;
      tick();
      chk_all("drop_grant", 2'b01, 2'b00, 1'b1, 3'd3);
      req = 2'b00; mode = 2'b00; steps0 = 3'd7;
      tick(); chk("drop_c4", 8'(count), 8'd4);
      tick(); chk("drop_c5", 8'(count), 8'd5);
      tick(); chk_all("drop_done", 2'b01, 2'b01, 1'b1, 3'd6);
      tick(); chk_all("drop_idle", 2'b00, 2'b00, 1'b0, 3'd6);

      // Reset mid-run: immediate, no clock edge needed
      req = 2'b01; mode = 2'b01; steps0 = 3'd5;
      tick();
      chk_all("rst_grant", 2'b01, 2'b00, 1'b1, 3'd6);
      tick(); chk("rst_c7", 8'(count), 8'd7);
      tick(); chk("rst_c0_wrap_up", 8'(count), 8'd0);
      tick(); chk("rst_c1", 8'(count), 8'd1);
      #2 reset = 1'b0;
      #1;
      chk_all("rst_async", 2'b00, 2'b00, 1'b0, 3'd0);
      req = 2'b00;
      tick();
      chk_all("rst_stay", 2'b00, 2'b00, 1'b0, 3'd0);
      reset = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
